apb_interrupt_cntrl_prio: RTL

//  Parametrised, priority-aware successor of the cluster APB interrupt controller. Latches NUM_IRQ event

---
 rtl/apb_interrupt_cntrl_prio.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_interrupt_cntrl_prio.sv
`default_nettype none
// ============================================================================
// Module   : apb_interrupt_cntrl_prio
// Purpose  : APB interrupt controller with per-line priority, global threshold,
//            registered request/ID handshake to the core and an optional event
//            FIFO whose non-empty state drives line FIFO_IRQ_ID.
//            Optional feature macro: APB_INTC_FIFO_EN (event FIFO present).
// Revision : 1.0 - initial release
// ============================================================================
module apb_interrupt_cntrl_prio #(
  parameter int NUM_IRQ      = 32,
  parameter int PRIO_WIDTH   = 3,
  parameter int EVT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_IRQ_ID  = 26
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IRQ-1:0]      events_i,
  input  logic                    evt_valid_i,
  output logic                    evt_ready_o,
  input  logic [EVT_ID_WIDTH-1:0] evt_data_i,
  output logic                    irq_req_o,
  output logic [4:0]              irq_id_o,
  output logic [PRIO_WIDTH-1:0]   irq_prio_o,
  input  logic                    irq_ack_i,
  input  logic [4:0]              irq_ack_id_i,
  input  logic [11:0]             paddr,
  input  logic [31:0]             pwdata,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr
);

  // Word addresses (paddr[11:2]) of the register map
  localparam logic [9:0] c_wa_mask      = 10'h000;
  localparam logic [9:0] c_wa_mask_set  = 10'h001;
  localparam logic [9:0] c_wa_mask_clr  = 10'h002;
  localparam logic [9:0] c_wa_pend      = 10'h003;
  localparam logic [9:0] c_wa_pend_set  = 10'h004;
  localparam logic [9:0] c_wa_pend_clr  = 10'h005;
  localparam logic [9:0] c_wa_ack       = 10'h006;
  localparam logic [9:0] c_wa_ack_set   = 10'h007;
  localparam logic [9:0] c_wa_ack_clr   = 10'h008;
  localparam logic [9:0] c_wa_fifo      = 10'h009;
  localparam logic [9:0] c_wa_thresh    = 10'h00A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // APB decode
  logic                  w_wr;
  logic [9:0]            w_wa;
  logic                  w_prio_region;
  logic [5:0]            w_prio_idx;
  logic [NUM_IRQ-1:0]    w_wdata;

  assign w_wr          = psel & penable & pwrite;
  assign w_wa          = paddr[11:2];
  assign w_prio_region = (paddr[11:8] == 4'h1);
  assign w_prio_idx    = paddr[7:2];
  assign w_wdata       = pwdata[NUM_IRQ-1:0];
  assign pready        = 1'b1;
  assign pslverr       = 1'b0;

  // Register state
  logic [NUM_IRQ-1:0]    r_mask;
  logic [NUM_IRQ-1:0]    r_pend;
  logic [NUM_IRQ-1:0]    r_ack;
  logic [PRIO_WIDTH-1:0] r_thresh;
  logic [PRIO_WIDTH-1:0] r_prio [NUM_IRQ];

  logic [NUM_IRQ-1:0]    w_pend_next;
  logic [NUM_IRQ-1:0]    w_ack_next;
  logic [NUM_IRQ-1:0]    w_hw_ack;
  logic [NUM_IRQ-1:0]    w_pend;
  logic [NUM_IRQ-1:0]    w_elig;
  logic [31:0]           w_elig32;

  // FIFO-facing signals shared by both build variants
  logic                  w_fifo_nonempty;
  logic [31:0]           w_fifo_rdata;
  logic                  w_evt_ready;
  logic                  w_unused;

`ifdef APB_INTC_FIFO_EN
  localparam logic [31:0]        c_fifo_mask32 = (FIFO_IRQ_ID < 32) ? (32'd1 << FIFO_IRQ_ID) : 32'd0;
  localparam logic [NUM_IRQ-1:0] c_fifo_line   = c_fifo_mask32[NUM_IRQ-1:0];
  localparam int                 c_aw          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_aw:0]      c_depth       = FIFO_DEPTH[c_aw:0];
  localparam logic [4:0]         c_fifo_id5    = FIFO_IRQ_ID[4:0];

  logic [EVT_ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]         r_wr_ptr;
  logic [c_aw-1:0]         r_rd_ptr;
  logic [c_aw:0]           r_count;
  logic [EVT_ID_WIDTH-1:0] r_fifo_id;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;

  assign w_full          = (r_count == c_depth);
  assign w_empty         = (r_count == '0);
  assign w_pop           = irq_ack_i & (irq_ack_id_i == c_fifo_id5) & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push
  assign w_evt_ready     = ~w_full | w_pop;
  assign w_push          = evt_valid_i & w_evt_ready;
  assign w_fifo_nonempty = ~w_empty;
  assign w_unused        = ^{paddr[1:0]};

  // FIFO storage, pointers (wrap by natural overflow) and popped-ID register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_fifo_id <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= evt_data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_fifo_id <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Zero-extend the popped ID for readback
  always_comb begin
    w_fifo_rdata = '0;
    w_fifo_rdata[EVT_ID_WIDTH-1:0] = r_fifo_id;
  end
`else
  localparam logic [NUM_IRQ-1:0] c_fifo_line = '0;

  assign w_evt_ready     = 1'b0;
  assign w_fifo_nonempty = 1'b0;
  assign w_fifo_rdata    = '0;
  assign w_unused        = ^{paddr[1:0], evt_valid_i, evt_data_i};
`endif

  assign evt_ready_o = w_evt_ready;

  // Per-line hardware acknowledge decode
  always_comb begin
    w_hw_ack = '0;
    for (int i = 0; i < NUM_IRQ; i++) w_hw_ack[i] = irq_ack_i & (irq_ack_id_i == 5'(i));
  end

  // Pending next value: ack clear beats a PEND write, which beats SET/CLR, which beats events
  always_comb begin
    w_pend_next = r_pend | events_i;
    if (w_wr && (w_wa == c_wa_pend))          w_pend_next = w_wdata;
    else if (w_wr && (w_wa == c_wa_pend_set)) w_pend_next = r_pend | events_i | w_wdata;
    else if (w_wr && (w_wa == c_wa_pend_clr)) w_pend_next = (r_pend | events_i) & ~w_wdata;
    w_pend_next = w_pend_next & ~w_hw_ack & ~c_fifo_line;
  end

  // Acknowledge history: software write first, then hardware acks OR in
  always_comb begin
    w_ack_next = r_ack;
    if (w_wr) begin
      case (w_wa)
        c_wa_ack:     w_ack_next = w_wdata;
        c_wa_ack_set: w_ack_next = r_ack | w_wdata;
        c_wa_ack_clr: w_ack_next = r_ack & ~w_wdata;
        default:      w_ack_next = r_ack;
      endcase
    end
    w_ack_next = w_ack_next | w_hw_ack;
  end

  // Configuration and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask   <= '0;
      r_pend   <= '0;
      r_ack    <= '0;
      r_thresh <= '0;
      for (int i = 0; i < NUM_IRQ; i++) r_prio[i] <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_ack  <= w_ack_next;
      if (w_wr) begin
        case (w_wa)
          c_wa_mask:     r_mask   <= w_wdata;
          c_wa_mask_set: r_mask   <= r_mask | w_wdata;
          c_wa_mask_clr: r_mask   <= r_mask & ~w_wdata;
          c_wa_thresh:   r_thresh <= pwdata[PRIO_WIDTH-1:0];
          default:       r_mask   <= r_mask;
        endcase
        if (w_prio_region) begin
          for (int i = 0; i < NUM_IRQ; i++)
            if (w_prio_idx == 6'(i)) r_prio[i] <= pwdata[PRIO_WIDTH-1:0];
        end
      end
    end
  end

  // Effective pending view: FIFO line reflects FIFO occupancy
  assign w_pend = (r_pend & ~c_fifo_line) | (w_fifo_nonempty ? c_fifo_line : '0);

  // Eligibility per line
  always_comb begin
    w_elig   = '0;
    w_elig32 = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      w_elig[i] = w_pend[i] & r_mask[i] & (r_prio[i] > r_thresh);
    w_elig32[NUM_IRQ-1:0] = w_elig;
  end

  // Arbiter: scan downward with >= so the lowest index wins a priority tie
  logic [PRIO_WIDTH-1:0] w_best_prio;
  logic [4:0]            w_win_id;
  logic                  w_any;

  always_comb begin
    w_best_prio = '0;
    w_win_id    = '0;
    w_any       = |w_elig;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (r_prio[i] >= w_best_prio)) begin
        w_best_prio = r_prio[i];
        w_win_id    = 5'(i);
      end
    end
  end

  // Handshake FSM
  state_t                r_state;
  state_t                w_state_next;
  logic                  r_irq_req;
  logic [4:0]            r_irq_id;
  logic [PRIO_WIDTH-1:0] r_irq_prio;
  logic                  w_win_live;

  assign w_win_live = w_elig32[r_irq_id];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state: ack of the presented ID wins over loss of eligibility
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_state_next = S_REQ;
      S_REQ: begin
        if (irq_ack_i && (irq_ack_id_i == r_irq_id)) w_state_next = S_HOLD;
        else if (!w_win_live)                        w_state_next = S_IDLE;
      end
      S_HOLD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Registered request outputs; winner captured only when leaving IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_req  <= 1'b0;
      r_irq_id   <= '0;
      r_irq_prio <= '0;
    end else begin
      r_irq_req <= (w_state_next == S_REQ);
      if ((r_state == S_IDLE) && w_any) begin
        r_irq_id   <= w_win_id;
        r_irq_prio <= w_best_prio;
      end
    end
  end

  assign irq_req_o  = r_irq_req;
  assign irq_id_o   = r_irq_id;
  assign irq_prio_o = r_irq_prio;

  // APB read mux; unmapped addresses return zero
  always_comb begin
    prdata = '0;
    case (w_wa)
      c_wa_mask, c_wa_mask_set, c_wa_mask_clr: prdata[NUM_IRQ-1:0] = r_mask;
      c_wa_pend, c_wa_pend_set, c_wa_pend_clr: prdata[NUM_IRQ-1:0] = w_pend;
      c_wa_ack, c_wa_ack_set, c_wa_ack_clr:    prdata[NUM_IRQ-1:0] = r_ack;
      c_wa_fifo:                               prdata = w_fifo_rdata;
      c_wa_thresh:                             prdata[PRIO_WIDTH-1:0] = r_thresh;
      default: begin
        if (w_prio_region) begin
          for (int i = 0; i < NUM_IRQ; i++)
            if (w_prio_idx == 6'(i)) prdata[PRIO_WIDTH-1:0] = r_prio[i];
        end
      end
    endcase
  end

endmodule
`default_nettype wire
